pingpong_bram: RTL and testbench

- Double-buffered dual-port feature-map store for the CNN datapath. The producer layer fills one bank while the consumer layer reads the other.
- Banks swap under explicit done/release handshakes, so a layer can start writing the next map before the previous one is fully consumed.
- Generalises the single simple-dual-port branch RAM: two banks, bank-ownership tracking, configurable read latency, sticky protocol-error flag.

---
 rtl/pingpong_bram_pkg.sv | 10 +
 rtl/pingpong_bram_if.sv | 30 +++
 rtl/pingpong_bram_bank.sv | 30 +++
 rtl/pingpong_bram.sv | 119 +++++++++++
 tb/tb_pingpong_bram.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pingpong_bram_pkg.sv
// Shared constants for the ping-pong feature-map store: bank indices and
// the read-latency legality check.
package pingpong_bram_pkg;
  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  function automatic bit rd_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction
endpackage

// File: rtl/pingpong_bram_if.sv
// Producer/consumer bus of the ping-pong store. The master drives strobes,
// the slave (the store) returns status and read data.
interface pingpong_bram_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]  wr_data;
  logic                  wr_done;
  logic                  wr_ready;
  logic                  wr_bank;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]  rd_data;
  logic                  rd_valid;
  logic                  rd_release;
  logic                  rd_ready;
  logic                  rd_bank;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_release,
    output wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, err
  );
endinterface

// File: rtl/pingpong_bram_bank.sv
// One simple-dual-port bank: synchronous write, registered read that holds
// its last word when not enabled. Storage is never reset.
module pingpong_bram_bank #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0]  rd_data
);
  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/pingpong_bram.sv
// Double-buffered feature-map store: producer fills one bank while the
// consumer drains the other; banks change hands on wr_done / rd_release.
module pingpong_bram
  import pingpong_bram_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  pingpong_bram_if.slave  bus
);
  localparam int STAGES = RD_LATENCY;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("pingpong_bram: RD_LATENCY must be 1 or 2");
  end

  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic              rsel_q, rsel_d;
  logic              err_q, err_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic              wr_ready, rd_ready, wr_fire, rd_fire;
  logic [RAM_WIDTH-1:0] bank_rd [2];
  logic [RAM_WIDTH-1:0] mux_data;

  assign wr_ready = !full_q[wr_sel_q];
  assign rd_ready = full_q[rd_sel_q];
  assign wr_fire  = bus.wr_en && wr_ready;
  assign rd_fire  = bus.rd_en && rd_ready;

  // wr_done and rd_release can only both be legal on opposite banks, so
  // applying them independently never collides on the same full bit.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (bus.wr_done && wr_ready) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    if (bus.rd_release && rd_ready) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
    err_d = err_q
          | (bus.wr_en      && !wr_ready) | (bus.wr_done    && !wr_ready)
          | (bus.rd_en      && !rd_ready) | (bus.rd_release && !rd_ready);
    rsel_d        = rd_fire ? rd_sel_q : rsel_q;
    vld_pipe_d[1] = rd_fire;
    for (int k = 2; k <= STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_sel_q   <= BANK0;
      rd_sel_q   <= BANK0;
      rsel_q     <= BANK0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      rsel_q     <= rsel_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BID = (b == 0) ? BANK0 : BANK1;
    pingpong_bram_bank #(
      .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .wr_en  (wr_fire && (wr_sel_q == BID)),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_en  (rd_fire && (rd_sel_q == BID)),
      .rd_addr(bus.rd_addr),
      .rd_data(bank_rd[b])
    );
  end

  // Bank registers only move on their own reads and rsel only on issue,
  // so this mux naturally holds the last delivered word.
  assign mux_data = (rsel_q == BANK1) ? bank_rd[1] : bank_rd[0];

  if (RD_LATENCY == 2) begin : g_out_reg
    logic [RAM_WIDTH-1:0] out_q, out_d;
    always_comb out_d = vld_pipe_q[1] ? mux_data : out_q;
    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
    end
    assign bus.rd_data = out_q;
  end else begin : g_out_gate
    // Bank registers have no reset; mask them until a read has landed.
    logic seen_q, seen_d;
    always_comb seen_d = seen_q | vld_pipe_q[1];
    always_ff @(posedge clk) begin
      if (rst) seen_q <= 1'b0;
      else     seen_q <= seen_d;
    end
    assign bus.rd_data = seen_d ? mux_data : '0;
  end

  assign bus.rd_valid = vld_pipe_q[STAGES];
  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.wr_bank  = wr_sel_q;
  assign bus.rd_bank  = rd_sel_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_pingpong_bram.sv
// Bench for pingpong_bram: latency-1 and latency-2 instances share stimulus;
// reads are scored against a queue holding expected word and due cycle.
module tb_pingpong_bram;
  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_exp;
    logic       rd_release;
    logic [4:0] exp;  // {wr_ready, rd_ready, wr_bank, rd_bank, err}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  sb_t        q1[$], q2[$];
  sb_t        e1, e2;
  vec_t       vt[19];

  pingpong_bram_if #(.RAM_WIDTH(8), .ADDR_WIDTH(4)) bus1();
  pingpong_bram_if #(.RAM_WIDTH(8), .ADDR_WIDTH(4)) bus2();

  assign bus1.wr_en = wr_en;      assign bus2.wr_en = wr_en;
  assign bus1.wr_addr = wr_addr;  assign bus2.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;  assign bus2.wr_data = wr_data;
  assign bus1.wr_done = wr_done;  assign bus2.wr_done = wr_done;
  assign bus1.rd_en = rd_en;      assign bus2.rd_en = rd_en;
  assign bus1.rd_addr = rd_addr;  assign bus2.rd_addr = rd_addr;
  assign bus1.rd_release = rd_release;
  assign bus2.rd_release = rd_release;

  pingpong_bram #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pingpong_bram #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL lat1_missing_valid: none by cycle %0d, required at %0d", cyc, q1[0].due);
      void'(q1.pop_front());
    end
    if (bus1.rd_valid === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL lat1_unexpected_valid: rd_valid=1 data=%h cycle %0d, required no valid", bus1.rd_data, cyc);
      end else begin
        e1 = q1.pop_front();
        if (bus1.rd_data !== e1.data || e1.due != cyc) begin
          n_bad++;
          $display("FAIL lat1_read: got %h at cycle %0d, required %h at cycle %0d", bus1.rd_data, cyc, e1.data, e1.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL lat2_missing_valid: none by cycle %0d, required at %0d", cyc, q2[0].due);
      void'(q2.pop_front());
    end
    if (bus2.rd_valid === 1'b1) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL lat2_unexpected_valid: rd_valid=1 data=%h cycle %0d, required no valid", bus2.rd_data, cyc);
      end else begin
        e2 = q2.pop_front();
        if (bus2.rd_data !== e2.data || e2.due != cyc) begin
          n_bad++;
          $display("FAIL lat2_read: got %h at cycle %0d, required %h at cycle %0d", bus2.rd_data, cyc, e2.data, e2.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic stat(input string nm, input logic [4:0] exp);
    chk({nm, "_lat1"}, {27'd0, bus1.wr_ready, bus1.rd_ready, bus1.wr_bank, bus1.rd_bank, bus1.err}, {27'd0, exp});
    chk({nm, "_lat2"}, {27'd0, bus2.wr_ready, bus2.rd_ready, bus2.wr_bank, bus2.rd_bank, bus2.err}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk); #1;
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // Drive a legal read and register what both instances must return.
  task automatic set_rd(input logic [3:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a;
    q1.push_back('{data: exp, due: cyc + 1});
    q2.push_back('{data: exp, due: cyc + 2});
  endtask

  task automatic do_reset();
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    q1.delete(); q2.delete();
  endtask

  task automatic fill_bank0();
    for (int i = 0; i < 16; i++) begin
      set_wr(4'(i), 8'(8'h10 + i));
      step();
    end
    wr_done = 1'b1;
    step();
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic wdn, input logic re, input logic [3:0] ra,
                              input logic [7:0] rx, input logic rel, input logic [4:0] ex);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_done = wdn;
    v.rd_en = re; v.rd_addr = ra; v.rd_exp = rx; v.rd_release = rel; v.exp = ex;
    return v;
  endfunction

  initial begin
    // Overlap scenario: read bank0 while writing bank1, then hand over.
    for (int i = 0; i < 16; i++)
      vt[i] = mk(1'b1, 4'(i), 8'(8'hA0 + i), 1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 5'b11100);
    vt[16] = mk(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 5'b01000);
    vt[17] = mk(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 5'b11010);
    vt[18] = mk(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd3, 8'hA3, 1'b0, 5'b11010);

    step(); step();
    rst = 1'b0;
    stat("reset_status", 5'b10000);
    chk("reset_rd_valid_lat1", bus1.rd_valid, 0);
    chk("reset_rd_valid_lat2", bus2.rd_valid, 0);
    chk("reset_rd_data_lat1", bus1.rd_data, 0);
    chk("reset_rd_data_lat2", bus2.rd_data, 0);

    fill_bank0();
    stat("after_fill_done", 5'b11100);
    set_rd(4'd5, 8'h15);
    step();
    chk("lat1_valid_at_1", bus1.rd_valid, 1);
    chk("lat1_data_at_1", bus1.rd_data, 8'h15);
    chk("lat2_valid_at_1", bus2.rd_valid, 0);
    step();
    chk("lat2_valid_at_2", bus2.rd_valid, 1);
    chk("lat2_data_at_2", bus2.rd_data, 8'h15);
    chk("lat1_hold_data", bus1.rd_data, 8'h15);
    chk("lat1_valid_drops", bus1.rd_valid, 0);

    for (int i = 0; i < 19; i++) begin
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      wr_done = vt[i].wr_done; rd_release = vt[i].rd_release;
      if (vt[i].rd_en) set_rd(vt[i].rd_addr, vt[i].rd_exp);
      step();
      stat($sformatf("overlap_vec%0d", i), vt[i].exp);
    end

    // Final read of bank0 issued together with its release.
    do_reset();
    fill_bank0();
    set_rd(4'd14, 8'h1E); step();
    set_rd(4'd15, 8'h1F); rd_release = 1'b1; step();
    stat("release_with_last_read", 5'b10110);

    // Write into a fully owned-by-reader store is dropped.
    do_reset();
    set_wr(4'd2, 8'h55); wr_done = 1'b1; step();
    set_wr(4'd2, 8'h66); wr_done = 1'b1; step();
    stat("both_full", 5'b01000);
    set_wr(4'd2, 8'hEE); step();
    stat("write_when_full_err", 5'b01001);
    set_rd(4'd2, 8'h55); step();

    do_reset();
    rd_en = 1'b1; rd_addr = 4'd0; step();
    stat("read_when_empty_err", 5'b10001);
    for (int i = 0; i < 3; i++) begin
      chk("empty_read_no_valid_lat1", bus1.rd_valid, 0);
      chk("empty_read_no_valid_lat2", bus2.rd_valid, 0);
      step();
    end

    do_reset();
    rd_release = 1'b1; step();
    stat("spurious_release_err", 5'b10001);

    // Simultaneous legal done and release, in both directions.
    do_reset();
    set_wr(4'd0, 8'h31); wr_done = 1'b1; step();
    stat("simul_setup", 5'b11100);
    set_wr(4'd0, 8'h42); wr_done = 1'b1; rd_release = 1'b1; step();
    stat("simul_swap_a", 5'b11010);
    set_rd(4'd0, 8'h42); step();
    set_wr(4'd1, 8'h53); wr_done = 1'b1; rd_release = 1'b1; step();
    stat("simul_swap_b", 5'b11100);
    set_rd(4'd1, 8'h53); step();
    repeat (3) step();

    // Reset arrives while a latency-2 read is still in flight.
    rd_en = 1'b1; rd_addr = 4'd1;
    q1.push_back('{data: 8'h53, due: cyc + 1});
    step();
    rst = 1'b1;
    step();
    chk("midrst_valid_lat2", bus2.rd_valid, 0);
    chk("midrst_data_lat2", bus2.rd_data, 0);
    chk("midrst_data_lat1", bus1.rd_data, 0);
    stat("midrst_status", 5'b10000);
    rst = 1'b0;
    step();
    chk("midrst_after_valid_lat2", bus2.rd_valid, 0);
    chk("midrst_after_data_lat2", bus2.rd_data, 0);

    repeat (4) step();
    chk("scoreboard_drained", q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
